// File: rtl/softcore_cpu_mult_pipe.sv
// Purpose : pipelined signed/unsigned DATA_W x DATA_W multiplier that returns the low or high product word.
// Latency : LATENCY (2..4) enabled clock edges from accepted operands to result_valid; one op per cycle.
// Backpr. : none beyond en; en=0 freezes every stage, flush drops all in-flight ops without touching result.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   en, flush             pipeline advance / synchronous kill of every valid bit
//   in_valid, src1, src2  operand handshake and operands (sampled only when en=1)
//   src1_signed, src2_signed, hi_sel   operand signedness, high/low result word select
//   result, result_valid  selected product word and its valid flag (result holds when invalid)
//   busy                  any stage, including the result register, holds a valid op
module softcore_cpu_mult_pipe #(
  parameter int DATA_W  = 32,
  parameter int PART_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              src1_signed,
  input  logic              src2_signed,
  input  logic              hi_sel,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy
);

  localparam int NSLICE = DATA_W / PART_W;
  localparam int NPART  = NSLICE * NSLICE;
  localparam int PP_W   = 2 * PART_W;
  localparam int PROD_W = 2 * DATA_W;
  // Number of pure-delay/partial-sum registers between stage 1 and the result register.
  localparam int NDELAY = (LATENCY > 2) ? (LATENCY - 2) : 0;

  if (LATENCY < 2 || LATENCY > 4) begin : g_bad_latency
    $error("softcore_cpu_mult_pipe: LATENCY must be in 2..4");
  end
  if ((DATA_W % PART_W) != 0) begin : g_bad_width
    $error("softcore_cpu_mult_pipe: DATA_W must be a multiple of PART_W");
  end

  // ------------------------------------------------------------------
  // Stage 1 inputs: unsigned slice products and the sign correction.
  // ------------------------------------------------------------------
  logic [PP_W-1:0]   pp_comb [NPART];
  logic [DATA_W-1:0] corr_comb;

  // Partial k multiplies src1 slice k/NSLICE by src2 slice k%NSLICE.
  always_comb begin
    for (int k = 0; k < NPART; k++) begin
      pp_comb[k] = PP_W'(src1[(k / NSLICE) * PART_W +: PART_W]) *
                   PP_W'(src2[(k % NSLICE) * PART_W +: PART_W]);
    end
  end

  // A signed negative operand is worth (raw - 2^DATA_W), so the unsigned
  // product needs -other<<DATA_W per such operand. Only the upper word is
  // affected and the 2^(2*DATA_W) cross term vanishes modulo the product
  // width, so both corrections collapse into one DATA_W-wide value.
  always_comb begin
    corr_comb = '0;
    if (src1_signed && src1[DATA_W-1]) begin
      corr_comb = corr_comb - src2;
    end
    if (src2_signed && src2[DATA_W-1]) begin
      corr_comb = corr_comb - src1;
    end
  end

  logic [PP_W-1:0]   s1_pp [NPART];
  logic [DATA_W-1:0] s1_corr;
  logic              s1_hi;
  logic              s1_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_hi   <= 1'b0;
      s1_corr <= '0;
      for (int k = 0; k < NPART; k++) begin
        s1_pp[k] <= '0;
      end
    end else begin
      if (flush) begin
        s1_vld <= 1'b0;
      end else if (en) begin
        s1_vld <= in_valid;
      end
      // Data only loads for real ops; bubbles leave the payload untouched.
      if (en && in_valid && !flush) begin
        s1_hi   <= hi_sel;
        s1_corr <= corr_comb;
        for (int k = 0; k < NPART; k++) begin
          s1_pp[k] <= pp_comb[k];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Accumulation of shifted partials plus correction, modulo 2^PROD_W.
  // ------------------------------------------------------------------
  logic [PROD_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int k = 0; k < NPART; k++) begin
      acc = acc + (PROD_W'(s1_pp[k]) << (PART_W * ((k / NSLICE) + (k % NSLICE))));
    end
    acc = acc + {s1_corr, {DATA_W{1'b0}}};
  end

  // ------------------------------------------------------------------
  // Optional summed-product registers between stage 1 and the result.
  // ------------------------------------------------------------------
  logic [PROD_W-1:0] fin_sum;
  logic              fin_hi;
  logic              fin_vld;
  logic              dly_busy;

  if (NDELAY == 0) begin : g_direct
    assign fin_sum  = acc;
    assign fin_hi   = s1_hi;
    assign fin_vld  = s1_vld;
    assign dly_busy = 1'b0;
  end else begin : g_delay
    logic [PROD_W-1:0] d_sum [NDELAY];
    logic [NDELAY-1:0] d_hi;
    logic [NDELAY-1:0] d_vld;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        d_vld <= '0;
        d_hi  <= '0;
        for (int k = 0; k < NDELAY; k++) begin
          d_sum[k] <= '0;
        end
      end else begin
        if (flush) begin
          d_vld <= '0;
        end else if (en) begin
          d_vld[0] <= s1_vld;
          for (int k = 1; k < NDELAY; k++) begin
            d_vld[k] <= d_vld[k-1];
          end
        end
        if (en) begin
          d_sum[0] <= acc;
          d_hi[0]  <= s1_hi;
          for (int k = 1; k < NDELAY; k++) begin
            d_sum[k] <= d_sum[k-1];
            d_hi[k]  <= d_hi[k-1];
          end
        end
      end
    end

    assign fin_sum  = d_sum[NDELAY-1];
    assign fin_hi   = d_hi[NDELAY-1];
    assign fin_vld  = d_vld[NDELAY-1];
    assign dly_busy = |d_vld;
  end

  // ------------------------------------------------------------------
  // Result register: word select; data only replaced by a completing op.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      if (flush) begin
        result_valid <= 1'b0;
      end else if (en) begin
        result_valid <= fin_vld;
      end
      if (en && fin_vld && !flush) begin
        result <= fin_hi ? fin_sum[PROD_W-1:DATA_W] : fin_sum[DATA_W-1:0];
      end
    end
  end

  assign busy = s1_vld | dly_busy | result_valid;

endmodule

// File: tb/tb_softcore_cpu_mult_pipe.sv
// Bench for softcore_cpu_mult_pipe: three instances (LATENCY 2, 3, 4) share one
// stimulus stream; an arithmetic reference model tracks every instance and is
// compared each cycle, with hand-computed literal checks pinning key results.
module tb_softcore_cpu_mult_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        src1_signed = 1'b0;
  logic        src2_signed = 1'b0;
  logic        hi_sel = 1'b0;

  logic [31:0] res [3];
  logic        rv  [3];
  logic        bz  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    softcore_cpu_mult_pipe #(
      .DATA_W (32),
      .PART_W (16),
      .LATENCY(g + 2)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .flush       (flush),
      .in_valid    (in_valid),
      .src1        (src1),
      .src2        (src2),
      .src1_signed (src1_signed),
      .src2_signed (src2_signed),
      .hi_sel      (hi_sel),
      .result      (res[g]),
      .result_valid(rv[g]),
      .busy        (bz[g])
    );
  end

  // Reference: extend each operand to 64 bits and multiply; the 64-bit
  // truncation is exactly the product modulo 2^64.
  function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb, input logic hi);
    logic [63:0] ea, eb, p;
    ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return hi ? p[63:32] : p[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: per latency, the last four accepted slots (index = enabled edges ago).
  // An op accepted at an enabled edge shows on result after LATENCY-1 more.
  logic        m_vld [3][4];
  logic [31:0] m_val [3][4];
  logic        e_rv  [3];
  logic [31:0] e_res [3];
  logic        m_cur_v;
  logic [31:0] m_cur;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 3; d++) begin
        for (int k = 0; k < 4; k++) begin
          m_vld[d][k] = 1'b0;
          m_val[d][k] = '0;
        end
        e_rv[d]  = 1'b0;
        e_res[d] = '0;
      end
    end else begin
      m_cur_v = in_valid && !flush;
      m_cur   = ref_word(src1, src2, src1_signed, src2_signed, hi_sel);
      for (int d = 0; d < 3; d++) begin
        if (en) begin
          for (int k = 3; k > 0; k--) begin
            m_vld[d][k] = m_vld[d][k-1];
            m_val[d][k] = m_val[d][k-1];
          end
          m_vld[d][0] = m_cur_v;
          m_val[d][0] = m_cur;
        end
        if (flush) begin
          for (int k = 0; k < 4; k++) m_vld[d][k] = 1'b0;
          e_rv[d] = 1'b0;
        end else if (en) begin
          e_rv[d] = m_vld[d][d+1];
          if (e_rv[d]) e_res[d] = m_val[d][d+1];
        end
      end
    end
  end

  function automatic logic exp_busy(input int d);
    logic b;
    b = 1'b0;
    for (int k = 0; k <= d + 1; k++) b = b | m_vld[d][k];
    return b;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(posedge clk) begin
    #2;
    if (reset_n) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("L%0d result_valid", d + 2), 32'(rv[d]), 32'(e_rv[d]));
        chk($sformatf("L%0d busy", d + 2), 32'(bz[d]), 32'(exp_busy(d)));
        chk($sformatf("L%0d result", d + 2), res[d], e_res[d]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb, input logic hi);
    in_valid    = 1'b1;
    src1        = a;
    src2        = b;
    src1_signed = sa;
    src2_signed = sb;
    hi_sel      = hi;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input int d, input string name, input logic [31:0] exp);
    chk({name, " data"}, res[d], exp);
    chk({name, " valid"}, 32'(rv[d]), 32'd1);
  endtask

  task automatic chk_all_zero(input string name);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s L%0d result", name, d + 2), res[d], 32'h0);
      chk($sformatf("%s L%0d valid", name, d + 2), 32'(rv[d]), 32'h0);
      chk($sformatf("%s L%0d busy", name, d + 2), 32'(bz[d]), 32'h0);
    end
  endtask

  // Unsigned all-ones squared, high then low word, checked at each latency.
  task automatic run_t1(input string tag);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    step();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    step();
    chk_out(0, {tag, " L2 hi"}, 32'hFFFF_FFFE);
    idle();
    step();
    chk_out(0, {tag, " L2 lo"}, 32'h0000_0001);
    chk_out(1, {tag, " L3 hi"}, 32'hFFFF_FFFE);
    step();
    chk_out(1, {tag, " L3 lo"}, 32'h0000_0001);
    chk_out(2, {tag, " L4 hi"}, 32'hFFFF_FFFE);
    step();
    chk_out(2, {tag, " L4 lo"}, 32'h0000_0001);
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b1;
    repeat (2) step();
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();

    // 1: unsigned x unsigned
    run_t1("t1");

    // 2: signed x signed
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    step();
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    step();
    chk_out(0, "t2 -1*-1 hi", 32'h0000_0000);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    step();
    chk_out(0, "t2 min^2 hi", 32'h4000_0000);
    idle();
    step();
    chk_out(0, "t2 min^2 lo", 32'h0000_0000);
    repeat (3) step();

    // 3: signed x unsigned
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    step();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step();
    chk_out(0, "t3 su hi", 32'hFFFF_FFFF);
    idle();
    step();
    chk_out(0, "t3 su lo", 32'h0000_0001);
    repeat (3) step();

    // 4: stall mid-stream; operands offered during the stall are ignored
    issue(32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
    step();
    issue(32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
    step();
    chk_out(0, "t4 7x6", 32'd42);
    issue(32'd3, 32'd9, 1'b0, 1'b0, 1'b0);
    step();
    chk_out(0, "t4 5x5", 32'd25);
    en = 1'b0;
    issue(32'd100, 32'd100, 1'b0, 1'b0, 1'b0);
    repeat (4) begin
      step();
      chk_out(0, "t4 stall hold", 32'd25);
    end
    en = 1'b1;
    idle();
    step();
    chk_out(0, "t4 3x9", 32'd27);
    step();
    chk("t4 drained valid", 32'(rv[0]), 32'd0);
    chk("t4 drained data", res[0], 32'd27);
    repeat (3) step();

    // 5: flush with two ops in flight and a third on the flush edge
    issue(32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    step();
    issue(32'd4, 32'd5, 1'b0, 1'b0, 1'b0);
    step();
    chk_out(0, "t5 2x3", 32'd6);
    issue(32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("t5 flush L%0d valid", d + 2), 32'(rv[d]), 32'd0);
      chk($sformatf("t5 flush L%0d busy", d + 2), 32'(bz[d]), 32'd0);
    end
    chk("t5 flush keeps data", res[0], 32'd6);
    flush = 1'b0;
    idle();
    step();
    chk("t5 no late valid", 32'(rv[0]), 32'd0);
    issue(32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    step();
    chk_out(0, "t5 3x4", 32'd12);
    repeat (3) step();

    // flush while stalled still kills in-flight ops
    issue(32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    en    = 1'b0;
    flush = 1'b1;
    step();
    chk("t5b stalled flush busy L4", 32'(bz[2]), 32'd0);
    flush = 1'b0;
    en    = 1'b1;
    repeat (3) step();

    // 6: asynchronous reset mid-operation, then latency re-check
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    step();
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("t6 async reset");
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    step();
    run_t1("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
